// File: rtl/rs_latch.sv
// Clock-synchronous active-low set/reset latch with optional strobe synchronizers
// and registered rise/fall pulses. Each bit is an independent rs_latch_bit instance.

module rs_latch_bit #(
    parameter int SET_DOM     = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sn_i,
    input  logic rn_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic SET_VAL = (SET_DOM != 0) ? 1'b1 : 1'b0;

    logic sn_s, rn_s;
    logic q_q, q_d;
    logic q_prev_q;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sn_s = sn_i;
        assign rn_s = rn_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sn_sync_q;
        logic [SYNC_STAGES-1:0] rn_sync_q;

        // Chains reload the deasserted level so a stale strobe cannot leak past reset.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sn_sync_q <= '1;
                rn_sync_q <= '1;
            end else begin
                sn_sync_q[0] <= sn_i;
                rn_sync_q[0] <= rn_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sn_sync_q[i] <= sn_sync_q[i-1];
                    rn_sync_q[i] <= rn_sync_q[i-1];
                end
            end
        end

        assign sn_s = sn_sync_q[SYNC_STAGES-1];
        assign rn_s = rn_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        q_d = q_q;
        case ({sn_s, rn_s})
            2'b01:   q_d = 1'b1;
            2'b10:   q_d = 1'b0;
            2'b00:   q_d = SET_VAL;
            default: q_d = q_q;
        endcase
    end

    // Edges are taken between the current and previous latch state, so pulses
    // trail the q change by one cycle.
    assign rise_d = q_q & ~q_prev_q;
    assign fall_d = ~q_q & q_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q      <= 1'b0;
            q_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            q_prev_q <= q_q;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

module rs_latch #(
    parameter int WIDTH       = 1,
    parameter int SET_DOM     = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sn,
    input  logic [WIDTH-1:0] rn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("rs_latch: SYNC_STAGES must be 0..3");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rs_latch_bit #(
            .SET_DOM    (SET_DOM),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_bit (
            .clk_i (clkin),
            .rst_ni(rstn),
            .sn_i  (sn[i]),
            .rn_i  (rn[i]),
            .q_o   (q[i]),
            .rise_o(q_rise[i]),
            .fall_o(q_fall[i])
        );
    end

    assign qn = ~q;

endmodule

// File: tb/tb_rs_latch.sv
// Scoreboarded directed test of rs_latch across four parameterizations sharing one clock.

module tb_rs_latch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: W1 set-dom no-sync, u1: W1 reset-dom, u2: W1 two-stage sync, u3: W4
    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
    logic       sn0 = 1'b1, rn0 = 1'b1, sn1 = 1'b1, rn1 = 1'b1, sn2 = 1'b1, rn2 = 1'b1;
    logic [3:0] sn3 = 4'hF, rn3 = 4'hF;
    logic       q0, qn0, r0, f0, q1, qn1, r1, f1, q2, qn2, r2, f2;
    logic [3:0] q3, qn3, r3, f3;

    rs_latch #(.WIDTH(1), .SET_DOM(1), .SYNC_STAGES(0)) u0 (
        .clkin(clk), .rstn(rst0), .sn(sn0), .rn(rn0), .q(q0), .qn(qn0), .q_rise(r0), .q_fall(f0));
    rs_latch #(.WIDTH(1), .SET_DOM(0), .SYNC_STAGES(0)) u1 (
        .clkin(clk), .rstn(rst1), .sn(sn1), .rn(rn1), .q(q1), .qn(qn1), .q_rise(r1), .q_fall(f1));
    rs_latch #(.WIDTH(1), .SET_DOM(1), .SYNC_STAGES(2)) u2 (
        .clkin(clk), .rstn(rst2), .sn(sn2), .rn(rn2), .q(q2), .qn(qn2), .q_rise(r2), .q_fall(f2));
    rs_latch #(.WIDTH(4), .SET_DOM(1), .SYNC_STAGES(0)) u3 (
        .clkin(clk), .rstn(rst3), .sn(sn3), .rn(rn3), .q(q3), .qn(qn3), .q_rise(r3), .q_fall(f3));

    typedef struct {
        int         id;
        int         seq;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq   = 0;

    function automatic void chk(input string name, input int s, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b want %b", name, s, act, exp);
        end
    endfunction

    // Drive one cycle of stimulus into DUT `id` (others idle) and queue the
    // outputs expected right after the next rising edge.
    task automatic step(input int id, input logic rst, input logic [3:0] s, input logic [3:0] r,
                        input logic [3:0] eq, input logic [3:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        sn0 = 1'b1; rn0 = 1'b1; sn1 = 1'b1; rn1 = 1'b1; sn2 = 1'b1; rn2 = 1'b1;
        sn3 = 4'hF; rn3 = 4'hF;
        case (id)
            0: begin rst0 = rst; sn0 = s[0]; rn0 = r[0]; end
            1: begin rst1 = rst; sn1 = s[0]; rn1 = r[0]; end
            2: begin rst2 = rst; sn2 = s[0]; rn2 = r[0]; end
            default: begin rst3 = rst; sn3 = s; rn3 = r; end
        endcase
        e.id = id; e.seq = seq; e.q = eq; e.rise = er; e.fall = ef;
        seq++;
        sbq.push_back(e);
    endtask

    // Monitor: every rising edge, retire one expectation against the addressed DUT.
    initial begin
        exp_t       e;
        logic [3:0] aq, aqn, ar, af, mask;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                mask = 4'b0001;
                case (e.id)
                    0: begin aq = {3'b0, q0}; aqn = {3'b0, qn0}; ar = {3'b0, r0}; af = {3'b0, f0}; end
                    1: begin aq = {3'b0, q1}; aqn = {3'b0, qn1}; ar = {3'b0, r1}; af = {3'b0, f1}; end
                    2: begin aq = {3'b0, q2}; aqn = {3'b0, qn2}; ar = {3'b0, r2}; af = {3'b0, f2}; end
                    default: begin aq = q3; aqn = qn3; ar = r3; af = f3; mask = 4'hF; end
                endcase
                chk($sformatf("u%0d.q", e.id), e.seq, aq, e.q);
                chk($sformatf("u%0d.qn", e.id), e.seq, aqn, ~e.q & mask);
                chk($sformatf("u%0d.q_rise", e.id), e.seq, ar, e.rise);
                chk($sformatf("u%0d.q_fall", e.id), e.seq, af, e.fall);
            end
        end
    end

    initial begin
        int waited;
        // u0 reset while sn held low, then set wins at first released edge
        repeat (3) step(0, 0, 1'b0, 1'b1, 0, 0, 0);
        step(0, 1, 1'b0, 1'b1, 1, 0, 0);
        step(0, 1, 1'b1, 1'b1, 1, 1, 0);
        repeat (9) step(0, 1, 1'b1, 1'b1, 1, 0, 0);
        step(0, 1, 1'b1, 1'b0, 0, 0, 0);
        step(0, 1, 1'b1, 1'b1, 0, 0, 1);
        step(0, 1, 1'b1, 1'b1, 0, 0, 0);
        // set then clear on consecutive cycles
        step(0, 1, 1'b0, 1'b1, 1, 0, 0);
        step(0, 1, 1'b1, 1'b0, 0, 1, 0);
        step(0, 1, 1'b1, 1'b1, 0, 0, 1);
        step(0, 1, 1'b1, 1'b1, 0, 0, 0);
        // simultaneous strobes, set dominant
        step(0, 1, 1'b0, 1'b0, 1, 0, 0);
        step(0, 1, 1'b1, 1'b1, 1, 1, 0);
        // level hold: sn low 5 cycles, single rise pulse
        step(0, 1, 1'b1, 1'b0, 0, 0, 0);
        step(0, 1, 1'b1, 1'b1, 0, 0, 1);
        step(0, 1, 1'b0, 1'b1, 1, 0, 0);
        step(0, 1, 1'b0, 1'b1, 1, 1, 0);
        repeat (3) step(0, 1, 1'b0, 1'b1, 1, 0, 0);
        step(0, 1, 1'b1, 1'b1, 1, 0, 0);
        // reset while q=1: no fall pulse
        step(0, 0, 1'b1, 1'b1, 0, 0, 0);
        repeat (2) step(0, 1, 1'b1, 1'b1, 0, 0, 0);

        // u1 reset dominant
        step(1, 0, 1'b1, 1'b1, 0, 0, 0);
        step(1, 1, 1'b0, 1'b1, 1, 0, 0);
        step(1, 1, 1'b0, 1'b0, 0, 1, 0);
        step(1, 1, 1'b1, 1'b1, 0, 0, 1);
        step(1, 1, 1'b0, 1'b0, 0, 0, 0);

        // u2 two-stage sync: q rises on 3rd edge after the strobe
        step(2, 0, 1'b1, 1'b1, 0, 0, 0);
        step(2, 1, 1'b0, 1'b1, 0, 0, 0);
        step(2, 1, 1'b1, 1'b1, 0, 0, 0);
        step(2, 1, 1'b1, 1'b1, 1, 0, 0);
        step(2, 1, 1'b1, 1'b1, 1, 1, 0);
        step(2, 1, 1'b1, 1'b1, 1, 0, 0);
        step(2, 1, 1'b1, 1'b0, 1, 0, 0);
        step(2, 1, 1'b1, 1'b1, 1, 0, 0);
        step(2, 1, 1'b1, 1'b1, 0, 0, 0);
        step(2, 1, 1'b1, 1'b1, 0, 0, 1);
        step(2, 1, 1'b1, 1'b1, 0, 0, 0);
        // set strobe caught in the chain, then reset: must be flushed
        step(2, 1, 1'b0, 1'b1, 0, 0, 0);
        step(2, 0, 1'b1, 1'b1, 0, 0, 0);
        repeat (3) step(2, 1, 1'b1, 1'b1, 0, 0, 0);

        // u3 multi-bit independence
        step(3, 0, 4'hF, 4'hF, 4'b0000, 4'b0000, 4'b0000);
        step(3, 1, 4'b1010, 4'hF, 4'b0101, 4'b0000, 4'b0000);
        step(3, 1, 4'hF, 4'hF, 4'b0101, 4'b0101, 4'b0000);
        step(3, 1, 4'hF, 4'b1110, 4'b0100, 4'b0000, 4'b0000);
        step(3, 1, 4'hF, 4'hF, 4'b0100, 4'b0000, 4'b0001);
        step(3, 1, 4'hF, 4'hF, 4'b0100, 4'b0000, 4'b0000);

        waited = 0;
        while (sbq.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_latch.md
# rs_latch

Clock-synchronous emulation of an active-low set/reset latch, used as the capture element of cross-domain pulse handshakes. A low on `sn` sets `q` and a low on `rn` clears it. With neither strobe asserted, the state holds. Optional input synchronizers and one-cycle edge pulses let the receiving domain consume the latched event directly.

## Interface
- `WIDTH`, default 1: number of independent latch bits.
- `SET_DOM`, default 1: 1 = set dominates when `sn` and `rn` are both low; 0 = reset dominates.
- `SYNC_STAGES`, default 0: synchronizer flops on `sn`/`rn` before the latch logic. Legal values are 0..3.
- `clkin`  input  1  single clock; all state updates on its rising edge.
- `rstn`  input  1  reset, synchronous and active-low.
- `sn`  input  WIDTH  active-low set strobe, per bit.
- `rn`  input  WIDTH  active-low clear strobe, per bit.
- `q`  output  WIDTH  latch state.
- `qn`  output  WIDTH  always the bitwise complement of `q`.
- `q_rise`  output  WIDTH  one-cycle pulse when `q` goes 0->1.
- `q_fall`  output  WIDTH  one-cycle pulse when `q` goes 1->0.

## Operation
- Each bit is independent; there is no cross-bit interaction.
- Synchronizer behaviour:
  - `SYNC_STAGES`=0: `sn`/`rn` are sampled directly at each edge.
  - `SYNC_STAGES`=N>0: each strobe passes through an N-flop chain. The latch logic uses the chain output (`sn_s`/`rn_s`).
- Per-bit next-state at each rising edge when `rstn`=1:
  - `sn_s`=0, `rn_s`=1 -> q=1.
  - `sn_s`=1, `rn_s`=0 -> q=0.
  - `sn_s`=0, `rn_s`=0 -> q=`SET_DOM`.
  - `sn_s`=1, `rn_s`=1 -> q holds.
- `qn` = ~`q` in every cycle, including during reset. There is no invalid q=qn state; this differs from a cross-coupled NAND latch.
- `q_rise`/`q_fall` are registered:
  - `q_rise` = q & ~q_prev.
  - `q_fall` = ~q & q_prev.
  - `q_prev` is `q` delayed one cycle.
  - `q_rise` and `q_fall` are never high together.
- Reset (`rstn`=0 at a rising edge):
  - `q`=0, `qn`=all ones, `q_prev`=0, `q_rise`=0, `q_fall`=0.
  - All synchronizer flops load 1, the deasserted level.
  - Reset overrides any strobe level.
- Strobe inputs are level-sensitive. Holding `sn` low keeps `q` at 1 (and likewise for `rn`), but `q_rise` pulses only once.
- Illegal `SYNC_STAGES` values (>3) must fail elaboration.

## Timing
- The latency below is for `SYNC_STAGES`=0. Each synchronizer stage adds one cycle of latency to `q`, `qn` and the pulses.
- `q` latency: `q` changes at the first rising edge where the strobe is sampled low, i.e. 1 edge after the strobe is applied.
- Pulse latency: `q_rise`/`q_fall` assert one cycle after the `q` change and last exactly one cycle.
- Reset release: after `rstn` returns high, the first edge evaluates strobes normally. Because the synchronizer chains are refilled with 1s, no spurious set or clear occurs for N cycles.
- Reset mid-operation: `q` is cleared at the reset edge. If `q` was 1, `q_fall` does not fire, because pulses are also forced to 0.
- Simultaneous set and clear: resolved in the same cycle by `SET_DOM`, with no intermediate value.
- Set-then-clear on consecutive cycles gives this sequence:
  - `q`: 1 for one cycle, then 0.
  - `q_rise`: one pulse.
  - `q_fall`: one pulse, in the cycle after `q_rise`.
- All outputs are registered except `qn`, which is combinational from the `q` register.

## Test plan
- Reset: `rstn`=0 for 3 cycles while `sn`=0 -> `q`=0, `qn`=1, `q_rise`=0, `q_fall`=0 throughout; after release, `q`=1 at the next edge.
- Set/hold/clear (WIDTH=1, SYNC_STAGES=0):
  - `sn` low 1 cycle -> `q`=1 at the next edge and holds for 10 cycles with strobes high.
  - Then `rn` low 1 cycle -> `q`=0.
  - `q_rise` and `q_fall` each pulse once, 1 cycle after the `q` change.
- Simultaneous strobes: `sn`=`rn`=0 -> `q`=1 with `SET_DOM`=1 and `q`=0 with `SET_DOM`=0; `qn` is always ~`q`.
- Synchronizer latency: `SYNC_STAGES`=2, `sn` low 1 cycle -> `q` rises on the 3rd edge after the strobe is applied; a reset pulse gives no spurious change for 2 cycles after release.
- Multi-bit independence (WIDTH=4):
  - `sn`=4'b1010 with `rn`=4'b1111 -> `q`=4'b0101.
  - Then `rn`=4'b1110 -> `q`=4'b0100, and only `q_fall`[0] pulses.
- Level hold: `sn` held low 5 cycles -> `q`=1 throughout; `q_rise` is a single one-cycle pulse.
